addsub_arbiter: RTL and testbench

Round-robin arbiter and result pipeline that shares one 16-bit signed add/subtract unit among N requesters in the ODE solver datapath. Each requester presents an operation with a valid/ready handshake. The arbiter grants at most one request per cycle, computes A+B or A−B with two's-complement overflow detection, and returns the result in a registered response slot tagged with the requester index. A sticky overflow status records any overflow since it was last cleared.

---
 rtl/addsub_arbiter.sv | 125 ++++++++++++
 tb/tb_addsub_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 16-bit signed add/subtract unit among N
// requesters, with a registered tagged response slot and sticky overflow flag.
module addsub_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_op,
  input  logic [16*N-1:0]   req_a,
  input  logic [16*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [15:0]       rsp_result,
  output logic              rsp_overflow,
  output logic              ovf_sticky,
  input  logic              ovf_clear
);

  localparam int unsigned DW = 16;

  logic [IW-1:0] ptr_q, ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          sticky_q, sticky_d;

  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [IW-1:0]  off_c;
  logic [IW:0]    sum_id_c;
  logic [IW-1:0]  gid_c;
  logic           found_c, free_c, accept_c;
  logic [DW-1:0]  a_c, b_c, b_eff_c, res_c;
  logic           op_c, ovf_c;

  assign free_c = !rsp_valid_q || rsp_ready;

  // Rotate requests so the pointer sits at bit 0, pick the lowest, rotate back.
  always_comb begin
    dbl_c    = {req_valid, req_valid} >> ptr_q;
    rot_c    = dbl_c[N-1:0];
    found_c  = 1'b0;
    off_c    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (rot_c[i] && !found_c) begin
        found_c = 1'b1;
        off_c   = IW'(i);
      end
    end
    sum_id_c = {1'b0, ptr_q} + {1'b0, off_c};
    if (sum_id_c >= (IW+1)'(N)) sum_id_c = sum_id_c - (IW+1)'(N);
    gid_c    = sum_id_c[IW-1:0];
    accept_c = found_c && free_c && !rst;
    req_ready = '0;
    if (accept_c) req_ready[gid_c] = 1'b1;
  end

  always_comb begin
    a_c  = '0;
    b_c  = '0;
    op_c = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (req_ready[i]) begin
        a_c  = req_a[i*DW +: DW];
        b_c  = req_b[i*DW +: DW];
        op_c = req_op[i];
      end
    end
    b_eff_c = op_c ? ~b_c : b_c;
    res_c   = a_c + b_eff_c + DW'(op_c);
    ovf_c   = op_c ? ((a_c[DW-1] != b_c[DW-1]) && (res_c[DW-1] != a_c[DW-1]))
                   : ((a_c[DW-1] == b_c[DW-1]) && (res_c[DW-1] != a_c[DW-1]));
  end

  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    sticky_d     = sticky_q;
    if (accept_c) begin
      ptr_d        = (gid_c == IW'(N-1)) ? '0 : gid_c + IW'(1);
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gid_c;
      rsp_result_d = res_c;
      rsp_ovf_d    = ovf_c;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
    // Setting on an overflowing accept takes priority over a clear.
    if (accept_c && ovf_c) sticky_d = 1'b1;
    else if (ovf_clear)    sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      sticky_q     <= sticky_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_ovf_q;
  assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: reset, single request, fairness,
// overflow/wrap, sticky flag, backpressure and mid-stream reset.
module tb_addsub_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_op;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_result;
  logic            rsp_overflow;
  logic            ovf_sticky;
  logic            ovf_clear;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  addsub_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic op,
                         input logic [15:0] a, input logic [15:0] b);
    req_valid[i]       = v;
    req_op[i]          = op;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [IW-1:0] id,
                           input logic [15:0] r, input logic o);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".id"},    32'(rsp_id), 32'(id));
    check({tag, ".result"}, 32'(rsp_result), 32'(r));
    check({tag, ".ovf"},   32'(rsp_overflow), 32'(o));
  endtask

  initial begin
    int exp_g;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; ovf_clear = 1'b0;

    // Reset: outputs cleared, arbitration gated even with requests present
    tick();
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'h0001, 16'h0001);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'h0);
    check_rsp("rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    check("rst.sticky", 32'(ovf_sticky), 32'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // Single request from requester 2: 3 + 4
    set_req(2, 1'b1, 1'b0, 16'h0003, 16'h0004);
    #1;
    check("single.req_ready", 32'(req_ready), 32'b0100);
    tick();
    check_rsp("single", 1'b1, 2'd2, 16'h0007, 1'b0);

    // Fairness: all valid, requester i computes i + 1; pointer now at 3
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'(i), 16'h0001);
    exp_g = 3;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("fair%0d.req_ready", k), 32'(req_ready), 32'(1) << exp_g);
      tick();
      check_rsp($sformatf("fair%0d", k), 1'b1, 2'(exp_g), 16'(exp_g + 1), 1'b0);
      exp_g = (exp_g + 1) % 4;
    end
    req_valid = '0;
    tick();
    check("drain.valid", 32'(rsp_valid), 32'h0);

    // Overflow and wrap via requester 0 alone
    set_req(0, 1'b1, 1'b0, 16'h7FFF, 16'h0001);
    #1;
    check("ovf1.req_ready", 32'(req_ready), 32'b0001);
    tick();
    check_rsp("ovf1", 1'b1, 2'd0, 16'h8000, 1'b1);
    check("ovf1.sticky", 32'(ovf_sticky), 32'h1);
    set_req(0, 1'b1, 1'b1, 16'h8000, 16'h0001);
    tick();
    check_rsp("ovf2", 1'b1, 2'd0, 16'h7FFF, 1'b1);
    set_req(0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    tick();
    check_rsp("ovf3", 1'b1, 2'd0, 16'h0000, 1'b0);
    check("ovf3.sticky", 32'(ovf_sticky), 32'h1);
    set_req(0, 1'b1, 1'b0, 16'h8000, 16'hFFFF);
    tick();
    check_rsp("ovf4", 1'b1, 2'd0, 16'h7FFF, 1'b1);
    req_valid = '0;
    ovf_clear = 1'b1;
    tick();
    check("clr.sticky", 32'(ovf_sticky), 32'h0);
    // Clear together with an overflowing accept: set wins
    set_req(0, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
    #1;
    check("setwin.req_ready", 32'(req_ready), 32'b0001);
    tick();
    check_rsp("setwin", 1'b1, 2'd0, 16'hFFFE, 1'b1);
    check("setwin.sticky", 32'(ovf_sticky), 32'h1);
    ovf_clear = 1'b0;
    req_valid = '0;
    tick();
    check("hold.sticky", 32'(ovf_sticky), 32'h1);

    // Backpressure: pointer at 1, requesters 1 and 3 valid
    set_req(1, 1'b1, 1'b1, 16'h0010, 16'h0005);
    set_req(3, 1'b1, 1'b0, 16'h1234, 16'h0001);
    #1;
    check("bp.first", 32'(req_ready), 32'b0010);
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'h0);
      check_rsp($sformatf("bp%0d", k), 1'b1, 2'd1, 16'h000B, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.release", 32'(req_ready), 32'b1000);
    tick();
    check_rsp("bp.next", 1'b1, 2'd3, 16'h1235, 1'b0);
    #1;
    check("bp.after", 32'(req_ready), 32'b0010);

    // Reset mid-stream with a pending response and pending requests
    rst = 1'b1;
    #1;
    check("mrst.req_ready0", 32'(req_ready), 32'h0);
    tick();
    check("mrst.valid", 32'(rsp_valid), 32'h0);
    check("mrst.sticky", 32'(ovf_sticky), 32'h0);
    check("mrst.req_ready1", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("mrst.first", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("mrst.rsp", 1'b1, 2'd1, 16'h000B, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
